// File: rtl/spi_master_mc_pkg.sv
// Shared types and constants for the multi-mode SPI master and its register wrapper.
package spi_master_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // Bit positions of the mode field as packed by the register wrapper.
    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;
    localparam int MODE_LSB_BIT  = 2;

    function automatic logic at_idle_level(input logic sclk, input logic cpol);
        return sclk == cpol;
    endfunction

endpackage

// File: rtl/spi_master_mc_clkgen.sv
// SCLK generator: divider down-counter with terminal-count tick, SCLK register and edge strobes.
module spi_master_mc_clkgen
    import spi_master_mc_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             run,
    input  logic             shift_en,
    output logic             tick,
    output logic             lead,
    output logic             trail,
    output logic             sclk
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             cpol_q;

    assign tick  = run && (cnt_q == '0);
    // SCLK still at idle level when the tick fires means this tick makes the leading edge.
    assign lead  = tick && shift_en && at_idle_level(sclk, cpol_q);
    assign trail = tick && shift_en && !at_idle_level(sclk, cpol_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            cpol_q <= 1'b0;
            sclk   <= 1'b0;
        end else if (load) begin
            div_q  <= div;
            cnt_q  <= div;
            cpol_q <= cpol;
            sclk   <= cpol;
        end else if (tick) begin
            cnt_q <= div_q;
            if (shift_en) begin
                sclk <= ~sclk;
            end
        end else if (run) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-mode SPI master: runtime divider, CPOL/CPHA, 1..DATA_W bit transfers, bit order, CS hold.
//
// state | meaning
// IDLE  | rdy=1, MOSI=1, CS kept low only if last transfer asked for hold
// SETUP | one half-period, CS asserted, SCLK at idle level, first bit on MOSI
// SHIFT | 2N SCLK edges, one per half-period
// HOLD  | one half-period at idle level, then result and rdy
module spi_master_mc
    import spi_master_mc_pkg::*;
#(
    parameter int   DATA_W = 32,
    parameter int   NUM_CS = 4,
    parameter int   DIV_W  = 8,
    localparam int  LEN_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1,
    localparam int  CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [LEN_W-1:0]  len,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cs_hold,
    input  logic [DATA_W-1:0] dataTx,
    output logic [DATA_W-1:0] dataRx,
    output logic              rdy,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCLK,
    output logic [NUM_CS-1:0] CS_N
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W - 1);

    spi_state_t        state_q, state_d;
    logic              cpha_q, lsb_q, cs_hold_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    edge_cnt_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_q;
    logic [NUM_CS-1:0] cs_n_q, cs_dec;
    logic              accept, tick, lead, trail, sample, drive, first_lead;

    assign rdy    = (state_q == ST_IDLE);
    assign accept = start && rdy;

    spi_master_mc_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .div      (div),
        .cpol     (cpol),
        .run      (!rdy),
        .shift_en (state_q == ST_SHIFT),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail),
        .sclk     (SCLK)
    );

    // With cpha=1 the first bit is already on MOSI from SETUP, so the first leading edge keeps it.
    assign first_lead = (edge_cnt_q == {len_q, 1'b1});
    assign sample     = cpha_q ? trail : lead;
    assign drive      = cpha_q ? (lead && !first_lead) : trail;

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (tick && edge_cnt_q == '0) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            cs_hold_q  <= 1'b0;
            len_q      <= '0;
            edge_cnt_q <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_q       <= '0;
            cs_n_q     <= '1;
        end else begin
            if (accept) begin
                cpha_q    <= cpha;
                lsb_q     <= lsb_first;
                cs_hold_q <= cs_hold;
                len_q     <= len;
                // MSB-first: left-justify so bit len leaves first from the top.
                tx_sr     <= lsb_first ? dataTx : (dataTx << (LEN_MAX - len));
                rx_sr     <= '0;
                cs_n_q    <= cs_dec;
            end
            if (state_q == ST_SETUP && tick) begin
                edge_cnt_q <= {len_q, 1'b1};
            end
            if (state_q == ST_SHIFT && tick) begin
                edge_cnt_q <= edge_cnt_q - 1'b1;
            end
            if (sample) begin
                rx_sr <= lsb_q ? {MISO, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], MISO};
            end
            if (drive) begin
                tx_sr <= lsb_q ? {1'b0, tx_sr[DATA_W-1:1]} : {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (state_q == ST_HOLD && tick) begin
                rx_q <= lsb_q ? (rx_sr >> (LEN_MAX - len_q)) : rx_sr;
                if (!cs_hold_q) begin
                    cs_n_q <= '1;
                end
            end
        end
    end

    assign MOSI   = rdy ? 1'b1 : (lsb_q ? tx_sr[0] : tx_sr[DATA_W-1]);
    assign CS_N   = cs_n_q;
    assign dataRx = rx_q;

endmodule
